// File: rtl/midi_pkg.sv
// midi_pkg: types and helpers shared by the MIDI merge arbiter.
//   arb_state_e    - message-lock state of the merge arbiter
//   byte_class_e   - data / status / realtime classification of a MIDI byte
//   byte_class()   - classify a byte
//   is_chan_status - true for channel-voice status bytes 8x..Ex
//   status_len()   - number of data bytes that follow a status byte
package midi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK  = 2'd1,
    ST_SYSEX = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    BC_DATA     = 2'd0,
    BC_STATUS   = 2'd1,
    BC_REALTIME = 2'd2
  } byte_class_e;

  localparam logic [7:0] SYSEX_START = 8'hF0;

  // F8..FF are realtime and may be slotted between any two bytes.
  function automatic byte_class_e byte_class(input logic [7:0] b);
    if (b[7:3] == 5'b11111) return BC_REALTIME;
    else if (b[7])          return BC_STATUS;
    else                    return BC_DATA;
  endfunction

  function automatic logic is_chan_status(input logic [7:0] b);
    return b[7] && (b[7:4] != 4'hF);
  endfunction

  // Data bytes following a status byte. F0 returns 0 here; the SysEx
  // case is flagged separately because its length is open-ended.
  function automatic logic [1:0] status_len(input logic [7:0] b);
    logic [1:0] n;
    n = 2'd0;
    case (b[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: n = 2'd2;
      4'hC, 4'hD:                   n = 2'd1;
      4'hF: begin
        case (b[3:0])
          4'h1, 4'h3: n = 2'd1;
          4'h2:       n = 2'd2;
          default:    n = 2'd0;
        endcase
      end
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/midi_msg_len.sv
// midi_msg_len: combinational status-byte length decoder.
//   stat_i  - status byte being granted
//   cnt_o   - data bytes that complete the message
//   sysex_o - byte opens a System Exclusive message (F0)
module midi_msg_len
  import midi_pkg::*;
(
  input  logic [7:0] stat_i,
  output logic [1:0] cnt_o,
  output logic       sysex_o
);

  assign cnt_o   = status_len(stat_i);
  assign sysex_o = (stat_i == SYSEX_START);

endmodule

// File: rtl/midi_merge_arb.sv
// midi_merge_arb: merges PORTS MIDI receive streams onto one transmitter,
// keeping multi-byte messages (including running status and SysEx) atomic
// while letting realtime bytes cut in.
//   clk, rst   - clock, synchronous active-high reset
//   rxdv       - per-port byte strobe from the receivers
//   rxdata     - per-port byte, port i at [i*8 +: 8]
//   route_mask - per-port enable for this output
//   tx_busy    - transmitter busy
//   txdv       - one-cycle transmit strobe
//   txdata     - byte to send (held until the next grant)
//   txcurport  - source port of txdata (held until the next grant)
//   overrun    - sticky per-port drop flags
//   ovr_clr    - clears all overrun flags
module midi_merge_arb
  import midi_pkg::*;
#(
  parameter int PORTS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PORTS-1:0]   rxdv,
  input  logic [PORTS*8-1:0] rxdata,
  input  logic [PORTS-1:0]   route_mask,
  input  logic               tx_busy,
  output logic               txdv,
  output logic [7:0]         txdata,
  output logic [3:0]         txcurport,
  output logic [PORTS-1:0]   overrun,
  input  logic               ovr_clr
);

  // ---------------------------------------------------------------- state
  logic [PORTS-1:0]        pend_q, pend_d;
  logic [PORTS-1:0][7:0]   hold_q, hold_d;
  logic [PORTS-1:0][1:0]   rlen_q, rlen_d;
  logic [PORTS-1:0]        ovr_q, ovr_d;
  arb_state_e              state_q, state_d;
  logic [1:0]              rem_q, rem_d;
  logic [3:0]              owner_q, owner_d;
  logic [3:0]              last_q, last_d;
  logic                    txdv_q;
  logic [7:0]              txdata_q;
  logic [3:0]              txport_q;

  // ------------------------------------------------------ classification
  logic [PORTS-1:0] elig, is_rt;

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      is_rt[i] = (byte_class(hold_q[i]) == BC_REALTIME);
    end
    // A masked-out port is invisible even if it still holds a byte.
    elig = pend_q & route_mask;
  end

  // ------------------------------------------------------ realtime pick
  logic       rt_any;
  logic [3:0] rt_idx;

  always_comb begin
    rt_any = 1'b0;
    rt_idx = '0;
    // Descending scan leaves the lowest index selected.
    for (int i = PORTS-1; i >= 0; i--) begin
      if (elig[i] && is_rt[i]) begin
        rt_any = 1'b1;
        rt_idx = 4'(i);
      end
    end
  end

  // -------------------------------------------------- round-robin pick
  // Lowest candidate above last_q wins; otherwise wrap to the lowest overall.
  logic       hi_any, lo_any, rr_any;
  logic [3:0] hi_idx, lo_idx, rr_idx;

  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = PORTS-1; i >= 0; i--) begin
      if (elig[i] && !is_rt[i]) begin
        lo_any = 1'b1;
        lo_idx = 4'(i);
        if (4'(i) > last_q) begin
          hi_any = 1'b1;
          hi_idx = 4'(i);
        end
      end
    end
    rr_any = lo_any;
    rr_idx = hi_any ? hi_idx : lo_idx;
  end

  // ------------------------------------------------------- owner status
  logic own_mask, own_elig, owner_drop;

  always_comb begin
    own_mask = 1'b0;
    own_elig = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (owner_q == 4'(i)) begin
        own_mask = route_mask[i];
        own_elig = elig[i] && !is_rt[i];
      end
    end
    // Owner unrouted mid-message: abandon the message.
    owner_drop = (state_q != ST_IDLE) && !own_mask;
  end

  // --------------------------------------------------------------- grant
  logic       issue_ok, nrt_any, gnt_vld, gnt_rt;
  logic [3:0] nrt_idx, gnt_idx;
  logic [7:0] gnt_byte;
  logic [1:0] gnt_rlen;

  always_comb begin
    // txdv_q covers the cycle before tx_busy rises.
    issue_ok = !tx_busy && !txdv_q;
    nrt_any  = (state_q == ST_IDLE) ? rr_any : own_elig;
    nrt_idx  = (state_q == ST_IDLE) ? rr_idx : owner_q;
    gnt_rt   = rt_any;
    gnt_vld  = issue_ok && (rt_any || nrt_any);
    gnt_idx  = rt_any ? rt_idx : nrt_idx;
    gnt_byte = '0;
    gnt_rlen = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (gnt_idx == 4'(i)) begin
        gnt_byte = hold_q[i];
        gnt_rlen = rlen_q[i];
      end
    end
  end

  logic [1:0] len_cnt;
  logic       len_sx;

  midi_msg_len u_len (
    .stat_i  (gnt_byte),
    .cnt_o   (len_cnt),
    .sysex_o (len_sx)
  );

  // ------------------------------------------------ message state machine
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    owner_d = owner_q;
    last_d  = last_q;
    rlen_d  = rlen_q;

    if (owner_drop) begin
      state_d = ST_IDLE;
      rem_d   = '0;
    end

    // Realtime grants never touch message state.
    if (gnt_vld && !gnt_rt) begin
      last_d = gnt_idx;
      if (gnt_byte[7]) begin
        // Any status byte (from IDLE or an owner aborting) starts fresh.
        owner_d = gnt_idx;
        if (len_sx) begin
          state_d = ST_SYSEX;
          rem_d   = '0;
        end else if (len_cnt != 2'd0) begin
          state_d = ST_LOCK;
          rem_d   = len_cnt;
        end else begin
          state_d = ST_IDLE;
          rem_d   = '0;
        end
        for (int i = 0; i < PORTS; i++) begin
          if (gnt_idx == 4'(i)) rlen_d[i] = is_chan_status(gnt_byte) ? len_cnt : 2'd0;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            // Running status: this data byte is the first of a new message.
            owner_d = gnt_idx;
            if (gnt_rlen > 2'd1) begin
              state_d = ST_LOCK;
              rem_d   = gnt_rlen - 2'd1;
            end
          end
          ST_LOCK: begin
            rem_d = rem_q - 2'd1;
            if (rem_q == 2'd1) state_d = ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // ------------------------------------------------- holding registers
  always_comb begin
    pend_d = pend_q;
    hold_d = hold_q;
    ovr_d  = ovr_q;
    for (int i = 0; i < PORTS; i++) begin
      logic acc, hit, drop_hit;
      acc      = rxdv[i] && route_mask[i];
      hit      = gnt_vld && (gnt_idx == 4'(i));
      drop_hit = owner_drop && (owner_q == 4'(i));
      // A byte landing on the edge its predecessor is granted fits.
      if (acc && (!pend_q[i] || hit)) begin
        pend_d[i] = 1'b1;
        hold_d[i] = rxdata[i*8 +: 8];
      end else if (hit || drop_hit) begin
        pend_d[i] = 1'b0;
      end
      if (acc && pend_q[i] && !hit) ovr_d[i] = 1'b1;
      else if (ovr_clr)             ovr_d[i] = 1'b0;
    end
  end

  // ---------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q   <= '0;
      hold_q   <= '0;
      rlen_q   <= '0;
      ovr_q    <= '0;
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      owner_q  <= '0;
      last_q   <= 4'(PORTS-1);
      txdv_q   <= 1'b0;
      txdata_q <= '0;
      txport_q <= '0;
    end else begin
      pend_q  <= pend_d;
      hold_q  <= hold_d;
      rlen_q  <= rlen_d;
      ovr_q   <= ovr_d;
      state_q <= state_d;
      rem_q   <= rem_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      txdv_q  <= gnt_vld;
      if (gnt_vld) begin
        txdata_q <= gnt_byte;
        txport_q <= gnt_idx;
      end
    end
  end

  assign txdv      = txdv_q;
  assign txdata    = txdata_q;
  assign txcurport = txport_q;
  assign overrun   = ovr_q;

endmodule

// File: doc/midi_merge_arb.md
MIDI_MERGE_ARB -- requirements
Module: midi_merge_arb

Interface
REQ-001 Parameter PORTS, default 4, range 1..16: number of input ports merged onto one output transmitter.
REQ-002 clk  in  1  sole clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 rxdv  in  PORTS  per-input one-cycle byte-valid strobe from the midi_port receivers.
REQ-005 rxdata  in  PORTS*8  per-input received byte; port i occupies bits [i*8+:8].
REQ-006 route_mask  in  PORTS  bit i = 1 routes input i to this output; 0 ignores input i entirely.
REQ-007 tx_busy  in  1  transmitter busy; rises the cycle after txdv, falls when the stop bit ends.
REQ-008 txdv  out  1  one-cycle transmit strobe.
REQ-009 txdata  out  8  byte to transmit; valid while txdv=1.
REQ-010 txcurport  out  4  source-port index of the byte on txdata; valid while txdv=1.
REQ-011 overrun  out  PORTS  sticky per-input drop flag.
REQ-012 ovr_clr  in  1  one-cycle pulse that clears all overrun bits.

Function
REQ-013 Each input shall have a one-byte holding register plus a pending flag; when rxdv[i]=1, route_mask[i]=1 and pending[i]=0, the byte shall be captured and pending[i] set on the next edge.
REQ-014 When rxdv[i]=1 with pending[i]=1, the new byte shall be dropped and overrun[i] set; if ovr_clr and the set condition coincide, set wins.
REQ-015 A byte shall be realtime when it is F8..FF; status when bit7=1 and not realtime; data when bit7=0.
REQ-016 Issue condition: tx_busy=0 and txdv=0 in the previous cycle; at most one byte issues per cycle.
REQ-017 Grant priority: pending realtime bytes first, lowest index wins, regardless of lock; otherwise non-realtime bytes per the state machine.
REQ-018 States: IDLE, LOCK, SYSEX; reset state IDLE.
REQ-019 IDLE: round-robin grant among pending non-realtime bytes, search starting at (last_grant+1) mod PORTS; the granted source becomes owner.
REQ-020 Granted status byte sets remaining count: 8x/9x/Ax/Bx/Ex=2, Cx/Dx=1, F1/F3=1, F2=2, F4/F5/F6/F7=0, F0=enter SYSEX; count>0 enters LOCK, count=0 stays IDLE.
REQ-021 Each source shall keep a 2-bit running-status length, updated on its channel-status grants (8x..Ex) and cleared to 0 by any system-common status (F0..F7) from that source.
REQ-022 Data byte granted in IDLE: remaining = running length minus 1; LOCK if the result is >0; a running length of 0 passes the byte through, staying in IDLE.
REQ-023 LOCK: only owner's non-realtime bytes issue; each issued data byte decrements remaining; at 0 return to IDLE.
REQ-024 LOCK or SYSEX: a status byte from the owner aborts the current message and is handled as in IDLE (new count or SYSEX).
REQ-025 SYSEX: only owner's non-realtime bytes issue; owner's F7 issues and returns to IDLE.
REQ-026 Clearing route_mask[owner] while in LOCK/SYSEX shall drop to IDLE next cycle and clear that source's pending flag.
REQ-027 Grant shall clear the source's pending flag on the same edge txdv is asserted; a byte captured on that edge is not an overrun.
REQ-028 txdata and txcurport shall be registered and held after txdv until the next grant.

Reset
REQ-029 While rst=1: txdv=0, txdata=0x00, txcurport=0, overrun=0, all pending=0, running lengths=0, state=IDLE, remaining=0, last_grant=PORTS-1.
REQ-030 Reset mid-message shall discard all held bytes; no txdv in the first cycle after rst deasserts.

Structure
REQ-031 Shared package midi_pkg shall hold the state enum, the byte-class function and the status-to-length function.
REQ-032 The length decoder shall be sub-module midi_msg_len (status byte in; count and sysex flag out, combinational); everything else is in midi_merge_arb.

Verification
REQ-033 PORTS=4, all masked in: port0 sends 90 3C 64 and port1 sends B0 07 7F interleaved byte-by-byte -> tx sequence 90 3C 64 B0 07 7F, txcurport 0,0,0,1,1,1.
REQ-034 Port2 in LOCK after 90; port3 sends F8 -> F8 issues next free slot with txcurport=3, then port2's message resumes intact.
REQ-035 Port1 sends F0 01 02 F7 while port0 holds C0 05 -> port0's bytes issue only after F7.
REQ-036 tx_busy held 1; port0 receives two bytes -> first held, second dropped, overrun=4'b0001; ovr_clr -> 4'b0000.
REQ-037 Port0 sends 90 3C 64, then running-status 3E 40 -> 3E and 40 issue atomically with txcurport=0.
REQ-038 rst asserted after 90 issued -> outputs zero, IDLE; following 3C from port0 passes through alone (length 0).
